// File: rtl/ddr2_cmd_sequencer.sv
// ddr2_cmd_sequencer: closed-page DDR2 ACT/RD|WR-autoprecharge sequencer with periodic auto-refresh
module ddr2_cmd_sequencer #(
  parameter int AL     = 3,
  parameter int CL     = 4,
  parameter int BL     = 8,
  parameter int T_RCDP = 1,
  parameter int T_WR   = 4,
  parameter int T_RP   = 4,
  parameter int T_RFC  = 51,
  parameter int T_REFI = 1950
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ck_slot,
  input  logic        ready,
  input  logic        cmd_notempty,
  input  logic [27:0] cmd_data,
  output logic        cmd_get,
  output logic        csbar,
  output logic        rasbar,
  output logic        casbar,
  output logic        webar,
  output logic [1:0]  ba,
  output logic [12:0] a,
  output logic        wr_launch,
  output logic        rd_launch,
  output logic [24:0] rd_addr,
  output logic        busy,
  output logic        ref_overrun
);
  localparam int RD_DONE = AL + CL + BL / 2 + T_RP - 1;
  localparam int WR_DONE = AL + CL - 1 + BL / 2 + T_WR + T_RP - 1;
  localparam int WL = AL + CL - 1;
  localparam int RL = AL + CL;
  typedef enum logic [1:0] {IDLE, ACT_WAIT, DONE_WAIT, REF_WAIT} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, ref_tmr;
  logic [7:0] wl_cnt, rl_cnt;
  logic [2:0] op_q;
  logic [24:0] addr_q;
  logic [3:0] cmd_n;
  logic [1:0] ba_n;
  logic [12:0] a_n;
  logic ref_pending, idle_eff, issue_ref, issue_cas, wrap, cmd_ok;
  // a wait state whose count has expired behaves as IDLE in that same slot
  assign idle_eff = state == IDLE || (state inside {DONE_WAIT, REF_WAIT} && cnt == '0);
  assign cmd_get = ready && ck_slot && cmd_notempty && !ref_pending && idle_eff;
  assign cmd_ok = cmd_data[27:25] == 3'b001 || cmd_data[27:25] == 3'b010;
  assign wrap = ck_slot && ref_tmr == 16'(T_REFI - 1);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cmd_n = 4'b0111;
    ba_n = ba;
    a_n = a;
    issue_ref = 1'b0;
    issue_cas = 1'b0;
    if (ck_slot) begin
      if (idle_eff) begin
        state_n = IDLE;
        if (ref_pending) begin
          state_n = REF_WAIT;
          cnt_n = 16'(T_RFC - 1);
          cmd_n = 4'b0001;
          issue_ref = 1'b1;
        end else if (cmd_get && cmd_ok) begin
          state_n = ACT_WAIT;
          cnt_n = 16'(T_RCDP - 1);
          cmd_n = 4'b0011;
          ba_n = cmd_data[11:10];
          a_n = cmd_data[24:12];
        end
      end else if (cnt != '0) cnt_n = cnt - 16'd1;
      else begin
        state_n = DONE_WAIT;
        cnt_n = op_q[0] ? 16'(RD_DONE) : 16'(WR_DONE);
        cmd_n = {3'b010, op_q[0]};
        ba_n = addr_q[11:10];
        a_n = {3'b001, addr_q[9:3], 3'b000};
        issue_cas = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      {csbar, rasbar, casbar, webar} <= 4'hf;
      ba <= '0;
      a <= '0;
      wr_launch <= 1'b0;
      rd_launch <= 1'b0;
      rd_addr <= '0;
      ref_overrun <= 1'b0;
      ref_pending <= 1'b0;
      ref_tmr <= '0;
      wl_cnt <= '0;
      rl_cnt <= '0;
      op_q <= '0;
      addr_q <= '0;
    end else if (!ready) begin
      state <= IDLE;
      cnt <= '0;
      {csbar, rasbar, casbar, webar} <= 4'hf;
      wr_launch <= 1'b0;
      rd_launch <= 1'b0;
      ref_pending <= 1'b0;
      ref_tmr <= '0;
      wl_cnt <= '0;
      rl_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wr_launch <= ck_slot && wl_cnt == 8'd1;
      rd_launch <= ck_slot && rl_cnt == 8'd1;
      if (cmd_get) begin
        op_q <= cmd_data[27:25];
        addr_q <= cmd_data[24:0];
      end
      if (ck_slot) begin
        {csbar, rasbar, casbar, webar} <= cmd_n;
        ba <= ba_n;
        a <= a_n;
        ref_tmr <= wrap ? '0 : ref_tmr + 16'd1;
        ref_pending <= wrap || (ref_pending && !issue_ref);
        ref_overrun <= ref_overrun || (wrap && ref_pending);
        wl_cnt <= issue_cas && !op_q[0] ? 8'(WL) : (wl_cnt != '0 ? wl_cnt - 8'd1 : '0);
        rl_cnt <= issue_cas && op_q[0] ? 8'(RL) : (rl_cnt != '0 ? rl_cnt - 8'd1 : '0);
        if (rl_cnt == 8'd1) rd_addr <= addr_q;
      end
    end
  end
endmodule
